// File: rtl/i2c_tx_fifo.sv
// i2c_tx_fifo: single-clock word FIFO with fill status and sticky overflow/underflow flags.
// Optional macro FIFO_FWFT_EN selects first-word-fall-through reads; default is registered read.
module i2c_tx_fifo #(
    parameter int unsigned DATAWIDTH  = 12,
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned AF_LEVEL   = 6
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  write_reset_n,
    input  logic                  read_reset_n,
    input  logic                  write_enable,
    input  logic [DATAWIDTH-1:0]  data_in,
    input  logic                  read_enable,
    output logic [DATAWIDTH-1:0]  data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [DATAWIDTH-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic [DEPTH_LOG2-1:0] widx;
    logic [DEPTH_LOG2-1:0] ridx;
    logic                  pop_ok;
    logic                  push_ok;

    assign widx = wptr[DEPTH_LOG2-1:0];
    assign ridx = rptr[DEPTH_LOG2-1:0];

    // Status is derived from the registered pointers; MSB of each pointer is the wrap bit.
    assign count       = wptr - rptr;
    assign empty       = (wptr == rptr);
    assign full        = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) && (widx == ridx);
    assign almost_full = (count >= AF_THRESH);

    // A pop frees a slot, so a push into a full FIFO is accepted alongside a pop.
    assign pop_ok  = read_enable & ~empty;
    assign push_ok = write_enable & (~full | pop_ok);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wptr     <= '0;
            overflow <= 1'b0;
        end else if (!write_reset_n) begin
            wptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (write_enable && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rptr      <= '0;
            underflow <= 1'b0;
        end else if (!read_reset_n) begin
            rptr      <= '0;
            underflow <= 1'b0;
        end else begin
            if (pop_ok) begin
                rptr <= rptr + PTR_ONE;
            end
            if (read_enable && !pop_ok) begin
                underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            mem <= '{default: '0};
        end else if (push_ok && write_reset_n) begin
            mem[widx] <= data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is always presented; stale and don't-care while empty.
    assign data_out = mem[ridx];
`else
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            data_out <= '0;
        end else if (!read_reset_n) begin
            data_out <= '0;
        end else if (pop_ok) begin
            data_out <= mem[ridx];
        end
    end
`endif

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// Scoreboard bench for i2c_tx_fifo: directed stimulus feeds an expected-word queue,
// a separate monitor compares popped data; status outputs are checked against a count model.
module tb_i2c_tx_fifo;

    logic        PCLK;
    logic        PRESETn;
    logic        write_reset_n;
    logic        read_reset_n;
    logic        write_enable;
    logic [11:0] data_in;
    logic        read_enable;
    logic [11:0] data_out;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    logic [11:0] exp_q[$];
    int          mc      = 0;
    logic        ov      = 1'b0;
    logic        uf      = 1'b0;
    logic        exp_pop = 1'b0;
    logic        pend    = 1'b0;

    i2c_tx_fifo dut (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .write_reset_n (write_reset_n),
        .read_reset_n  (read_reset_n),
        .write_enable  (write_enable),
        .data_in       (data_in),
        .read_enable   (read_enable),
        .data_out      (data_out),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_status();
        chk("count",       32'(count),       32'(mc));
        chk("empty",       32'(empty),       32'(mc == 0));
        chk("full",        32'(full),        32'(mc == 8));
        chk("almost_full", 32'(almost_full), 32'(mc >= 6));
        chk("overflow",    32'(overflow),    32'(ov));
        chk("underflow",   32'(underflow),   32'(uf));
    endtask

    // One clock of stimulus; status from the previous edge is checked first.
    task automatic step(input logic we, input logic [11:0] din, input logic re,
                        input logic clr = 1'b0);
        logic pop;
        logic push;
        @(negedge PCLK);
        check_status();
        write_enable  = we;
        data_in       = din;
        read_enable   = re;
        write_reset_n = ~clr;
        read_reset_n  = ~clr;
        if (clr) begin
            mc = 0;
            ov = 1'b0;
            uf = 1'b0;
            exp_q.delete();
            exp_pop = 1'b0;
        end else begin
            pop  = re && (mc != 0);
            push = we && ((mc != 8) || pop);
            if (we && !push) ov = 1'b1;
            if (re && mc == 0) uf = 1'b1;
            if (push) exp_q.push_back(din);
            mc = mc + int'(push) - int'(pop);
            exp_pop = pop;
        end
    endtask

    task automatic pop_compare();
        logic [11:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_data actual=%0h expected=<none queued>", data_out);
        end else begin
            e = exp_q.pop_front();
            chk("pop_data", 32'(data_out), 32'(e));
        end
    endtask

`ifdef FIFO_FWFT_EN
    always @(posedge PCLK) begin
        if (exp_pop && PRESETn) pop_compare();
    end
`else
    always @(posedge PCLK) pend <= exp_pop & PRESETn;
    always @(negedge PCLK) begin
        if (pend) pop_compare();
    end
`endif

    initial begin
        PRESETn       = 1'b0;
        write_reset_n = 1'b1;
        read_reset_n  = 1'b1;
        write_enable  = 1'b0;
        read_enable   = 1'b0;
        data_in       = '0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
`ifndef FIFO_FWFT_EN
        chk("reset_data_out", 32'(data_out), 32'h0);
`endif

        // Basic ordering
        step(1'b1, 12'h0A1, 1'b0);
        step(1'b1, 12'h0B2, 1'b0);
        step(1'b1, 12'h0C3, 1'b0);
        repeat (3) step(1'b0, 12'h0, 1'b1);
        repeat (2) step(1'b0, 12'h0, 1'b0);

        // Fill to full, rejected 9th push, drain
        for (int i = 0; i < 8; i++) step(1'b1, 12'(12'h100 + i), 1'b0);
        step(1'b1, 12'h1FF, 1'b0);
        repeat (8) step(1'b0, 12'h0, 1'b1);
        step(1'b0, 12'h0, 1'b0);

        // Underflow keeps data_out; push+pop on empty accepts only the push
        step(1'b0, 12'h0, 1'b1);
        step(1'b0, 12'h0, 1'b0);
`ifndef FIFO_FWFT_EN
        chk("underflow_data_hold", 32'(data_out), 32'h107);
`endif
        step(1'b1, 12'h055, 1'b1);
        step(1'b0, 12'h0, 1'b1);
        step(1'b0, 12'h0, 1'b0);

        // Flush with 5 words held and overflow still set
        for (int i = 0; i < 5; i++) step(1'b1, 12'(12'h200 + i), 1'b0);
        step(1'b0, 12'h0, 1'b0, 1'b1);
        step(1'b0, 12'h0, 1'b0);
`ifndef FIFO_FWFT_EN
        chk("flush_data_out", 32'(data_out), 32'h0);
`endif

        // Push and pop together while full
        for (int i = 0; i < 8; i++) step(1'b1, 12'(12'h300 + i), 1'b0);
        step(1'b1, 12'h2AA, 1'b1);
        repeat (8) step(1'b0, 12'h0, 1'b1);
        repeat (2) step(1'b0, 12'h0, 1'b0);

        // Streaming across the pointer wrap
        for (int i = 0; i < 20; i++) step(1'b1, 12'(12'h400 + i), i != 0);
        step(1'b0, 12'h0, 1'b1);
        repeat (2) step(1'b0, 12'h0, 1'b0);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) step(1'b1, 12'(12'h500 + i), 1'b0);
        @(posedge PCLK);
        #2;
        write_enable = 1'b0;
        PRESETn      = 1'b0;
        mc = 0;
        ov = 1'b0;
        uf = 1'b0;
        exp_q.delete();
        exp_pop = 1'b0;
        #1;
        chk("rst_count",       32'(count),       32'h0);
        chk("rst_empty",       32'(empty),       32'h1);
        chk("rst_full",        32'(full),        32'h0);
        chk("rst_almost_full", 32'(almost_full), 32'h0);
        chk("rst_overflow",    32'(overflow),    32'h0);
        chk("rst_underflow",   32'(underflow),   32'h0);
        chk("rst_data_out",    32'(data_out),    32'h0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        // Recovery after reset
        step(1'b1, 12'h0AB, 1'b0);
        step(1'b0, 12'h0, 1'b1);
        repeat (3) step(1'b0, 12'h0, 1'b0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_tx_fifo.md
# i2c_tx_fifo

Single-clock synchronous FIFO between the APB register slave and the I2C byte engine. It buffers 12-bit words written into the transmit register and releases them to the I2C engine one word per pop. It reports full, empty, fill level and sticky error flags back to the status register. The same block is instantiated a second time as the receive FIFO, with the producer and consumer roles swapped.

## Interface
Parameters:
- DATAWIDTH, 12, word width.
- DEPTH_LOG2, 3, log2 of the entry count; depth is 8 by default.
- AF_LEVEL, 6, fill level at or above which almost_full asserts; legal range 1..2^DEPTH_LOG2.

Ports:
- PCLK  in  1  clock; all state updates on the rising edge.
- PRESETn  in  1  asynchronous active-low reset; clears all state.
- write_reset_n  in  1  synchronous active-low write-side clear.
- read_reset_n  in  1  synchronous active-low read-side clear.
- write_enable  in  1  push request; one push per cycle while high.
- data_in  in  DATAWIDTH  push data, sampled on the push edge.
- read_enable  in  1  pop request; one pop per cycle while high.
- data_out  out  DATAWIDTH  pop data; timing depends on FIFO_FWFT_EN.
- full  out  1  count == 2^DEPTH_LOG2.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- count  out  DEPTH_LOG2+1  current fill level.
- overflow  out  1  sticky; set by a rejected push.
- underflow  out  1  sticky; set by a rejected pop.

## Operation
Storage:
- Entry array of 2^DEPTH_LOG2 words.
- wptr and rptr are each DEPTH_LOG2+1 bits. The MSB is the wrap bit; the low bits index the array.
- count = wptr - rptr, modulo 2^(DEPTH_LOG2+1).
- full when the pointer MSBs differ and the low bits are equal. empty when the pointers are equal.

Accept rules:
- pop_ok = read_enable & !empty.
- push_ok = write_enable & (!full | pop_ok). Push and pop are allowed on the same cycle when full.
- Simultaneous push and pop when empty: the push is accepted, the pop is rejected, underflow sets, and count becomes 1.
- Simultaneous push and pop at 0 < count < depth: both are accepted and count is unchanged.
- A push writes data_in to the array at wptr and increments wptr. A pop increments rptr.
- Pointers wrap naturally at 2^(DEPTH_LOG2+1). There is no saturation logic.

Errors:
- A rejected push sets overflow; the data is dropped, and both array and wptr are unchanged.
- A rejected pop sets underflow; rptr and data_out are unchanged.
- Flags stay set until the matching side clear or PRESETn.

Side clears:
- write_reset_n low: wptr and overflow go to 0. Pushes on that cycle are ignored.
- read_reset_n low: rptr and underflow go to 0. Pops on that cycle are ignored; data_out goes to 0 in registered mode.
- A clean flush requires both clears low on the same cycle. A one-sided clear leaves count defined by the pointer arithmetic, with no further guarantee.

## Timing
- Reset values (PRESETn low): wptr=0, rptr=0, every array entry=0, data_out=0, empty=1, full=0, almost_full=0, count=0, overflow=0, underflow=0.
- PRESETn may assert mid-stream; all state clears immediately, with no drain.
- full, empty, almost_full and count are derived combinationally from the registered pointers, so they reflect a push or pop on the cycle after its edge.
- Throughput: one push and one pop per cycle. Pushed data is poppable on the cycle after the push edge; the FIFO does not bypass data_in to data_out within the same cycle.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through.
  - data_out = array[rptr] combinationally and is valid whenever empty=0.
  - read_enable acknowledges the current word, and the next word appears after the edge.
  - While empty, data_out shows the stale array entry and is don't-care.
- FIFO_FWFT_EN undefined: registered read.
  - On a pop_ok edge, data_out <= array[rptr], so the data is valid one cycle after read_enable.
  - data_out holds its value on all other cycles.

## Test plan
- Reset, then push 0x0A1, 0x0B2, 0x0C3 on consecutive cycles -> count=3, empty=0. Three pops -> 0x0A1, 0x0B2, 0x0C3 in order (registered mode: each one cycle after its read_enable); then empty=1.
- Push 8 words 0x100..0x107 -> full=1, count=8, almost_full=1 from count 6. A 9th push of 0x1FF -> overflow=1, and the subsequent 8 pops return 0x100..0x107 only.
- When full, push 0x2AA and pop on the same cycle -> pop returns the oldest word, count stays 8, overflow stays 0, and 0x2AA emerges 8th.
- When empty, pop -> underflow=1, data_out unchanged, count=0. Simultaneous push 0x055 and pop when empty -> count=1 and 0x055 is read on the next pop.
- Push 20 words with a pop on every cycle after the first, crossing the pointer wrap -> output sequence identical to the input and count never exceeds 2.
- With 5 words held and overflow set, pulse write_reset_n and read_reset_n low together for one cycle -> count=0, empty=1, overflow=0. PRESETn pulsed mid-burst -> all outputs return to their reset values immediately.
